// File: rtl/lt24_mem_pkg.sv
// ----------------------------------------------------------------------------
// lt24_mem_pkg
//   Shared types and default sizes for the LT24 on-chip-memory read master
//   and its stream-side helpers.
//   - state_t        : read master sequencing states
//   - *_DEF          : default bus / count / buffer sizes
//   - FIFO_AW        : pointer width of the default-depth output buffer
// ----------------------------------------------------------------------------
package lt24_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned ADDR_W_DEF     = 17;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned CNT_W_DEF      = 17;
   localparam int unsigned FIFO_DEPTH_DEF = 8;
   localparam int unsigned FIFO_AW        = $clog2(FIFO_DEPTH_DEF);

endpackage

// File: rtl/lt24_qsys_mem_read_master_if.sv
// ----------------------------------------------------------------------------
// lt24_qsys_mem_read_master_if
//   Bundles the command, Avalon-MM read and Avalon-ST source signals of the
//   LT24 memory read master.
//   Command : start, start_address, word_count -> busy, done
//   Avalon-MM: avm_address, avm_read <- avm_waitrequest, avm_readdata,
//              avm_readdatavalid
//   Avalon-ST: src_data, src_valid <- src_ready
//   modport master : view of the read master itself
//   modport slave  : view of the surrounding system (controller, memory, sink)
// ----------------------------------------------------------------------------
interface lt24_qsys_mem_read_master_if
   import lt24_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) ();

   logic              start;
   logic [ADDR_W-1:0] start_address;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;

   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;

   logic [DATA_W-1:0] src_data;
   logic              src_valid;
   logic              src_ready;

   modport master (
      input  start, start_address, word_count,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  src_ready,
      output busy, done,
      output avm_address, avm_read,
      output src_data, src_valid
   );

   modport slave (
      output start, start_address, word_count,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      output src_ready,
      input  busy, done,
      input  avm_address, avm_read,
      input  src_data, src_valid
   );

endinterface

// File: rtl/lt24_sync_fifo.sv
// ----------------------------------------------------------------------------
// lt24_sync_fifo
//   Show-ahead synchronous FIFO: o_data always presents the oldest word.
//   Push and pop may occur in the same cycle, including when full.
//   clk, rst : clock, asynchronous active-high reset (flushes contents)
//   i_push   : write i_data (ignored when full unless popping)
//   i_pop    : consume head word (ignored when empty)
//   o_data   : head word, valid while o_empty = 0
//   o_count  : number of stored words, 0..DEPTH
//   o_empty, o_full : occupancy flags
// ----------------------------------------------------------------------------
module lt24_sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic [CW-1:0]     o_count,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic w_push;
   logic w_pop;

   assign w_pop  = i_pop & ~o_empty;
   // a full FIFO still accepts a word when the head leaves in the same cycle
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/lt24_qsys_mem_read_master.sv
// ----------------------------------------------------------------------------
// lt24_qsys_mem_read_master
//   Avalon-MM pipelined read master that fetches word_count consecutive
//   words starting at start_address and streams them, in address order, on
//   an Avalon-ST source toward the LT24 pixel consumers.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : command (start/start_address/word_count -> busy/done),
//                Avalon-MM read port and Avalon-ST source
//   Reads are only issued while the output buffer is guaranteed room for
//   every word already requested, so src_ready may stall indefinitely.
// ----------------------------------------------------------------------------
module lt24_qsys_mem_read_master
   import lt24_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   lt24_qsys_mem_read_master_if.master  bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = AW + 2;

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_read;
   logic [ADDR_W-1:0] r_address;
   logic [CNT_W-1:0]  r_remaining;
   logic [CW-1:0]     r_pending;

   logic [DATA_W-1:0] w_fifo_data;
   logic [CW-1:0]     w_fifo_count;
   logic              w_fifo_empty;
   logic              w_fifo_full;

   logic              w_accept;
   logic              w_rsp;
   logic              w_push;
   logic              w_pop;
   logic              w_last;
   logic              w_credit;
   logic [OW-1:0]     w_occupancy;

   assign w_accept = r_read & ~bus.avm_waitrequest;
   // responses with nothing outstanding are stale (e.g. issued before a reset)
   assign w_rsp    = bus.avm_readdatavalid & (r_pending != '0);
   assign w_pop    = ~w_fifo_empty & bus.src_ready;
   assign w_push   = w_rsp & (~w_fifo_full | w_pop);
   assign w_last   = (r_remaining == CNT_W'(1));

   // Words buffered plus words requested, including the one accepted this
   // cycle; pops are ignored so the estimate can only err on the safe side.
   assign w_occupancy = OW'(w_fifo_count) + OW'(r_pending) + OW'(w_accept);
   assign w_credit    = (w_occupancy < OW'(FIFO_DEPTH));

   lt24_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (bus.avm_readdata),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_read      <= 1'b0;
         r_address   <= '0;
         r_remaining <= '0;
         r_pending   <= '0;
      end else begin
         r_done <= 1'b0;

         case ({w_accept, w_rsp})
            2'b10:   r_pending <= r_pending + CW'(1);
            2'b01:   r_pending <= r_pending - CW'(1);
            default: r_pending <= r_pending;
         endcase

         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.word_count == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_address   <= bus.start_address;
                     r_remaining <= bus.word_count;
                     r_busy      <= 1'b1;
                     r_read      <= 1'b1;
                     r_state     <= READ;
                  end
               end
            end

            READ: begin
               if (w_accept) begin
                  r_address   <= r_address + ADDR_W'(1);
                  r_remaining <= r_remaining - CNT_W'(1);
                  if (w_last) begin
                     r_read  <= 1'b0;
                     r_state <= DRAIN;
                  end else begin
                     r_read <= w_credit;
                  end
               end else if (!r_read) begin
                  r_read <= w_credit;
               end
               // r_read high and stalled: request and address are held
            end

            DRAIN: begin
               if ((r_pending == '0) && w_fifo_empty) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_read  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.avm_read    = r_read;
   assign bus.avm_address = r_address;
   assign bus.src_data    = w_fifo_data;
   assign bus.src_valid   = ~w_fifo_empty;

endmodule
